obstacle_manager: RTL and testbench
===================================

Name: obstacle_manager

Overview:
Owns the 10-slot obstacle table consumed by the track renderer. It spawns obstacles on request, scrolls them left once per video frame and retires them when they leave the screen. Packed slot format, identical to the renderer's: [14:13] type, [12:3] x position, [2:1] lane, [0] active. Sits between the game-logic spawn generator and the track drawing path.

Parameters:
NUM_SLOTS, 10, table depth (fixed at 10 to match renderer)
SPAWN_POS, 1023, x position written into a newly spawned slot (10 bits)
SPEED_W, 4, width of scroll speed input

Ports:
system_clock_in  input  1  system clock
reset_n_in  input  1  asynchronous active-low reset
vsync_in  input  1  video vsync, active-low pulse; falling edge = frame tick
pause_in  input  1  while high, frame ticks are ignored
clear_in  input  1  synchronous wipe of all slots (game restart)
speed_in  input  SPEED_W  pixels scrolled per frame, sampled at tick
spawn_valid_in  input  1  spawn request valid
spawn_ready_out  output  1  spawn request may be accepted
spawn_type_in  input  2  obstacle type
spawn_lane_in  input  2  lane 0..2; 3 is invalid
obstacles_out  output  15 x [9:0]  registered slot table
active_count_out  output  4  number of active slots
passed_out  output  1  one-cycle pulse per retired obstacle
busy_out  output  1  high during scroll pass

Behaviour:
- Reset (async, reset_n_in low): all obstacles_out = 0, active_count_out = 0, passed_out = 0, spawn_ready_out = 0, busy_out = 0, FSM = IDLE, pending tick cleared, vsync edge register = 1.
- Tick detect: vsync_in registered once; tick = prev 1 and current 0. A tick with pause_in high is dropped. An unpaused tick sets a 1-deep pending flag; a second tick while pending is still set is dropped.
- FSM IDLE: spawn_ready_out = 1 iff at least one slot is inactive and no pending tick. If pending is set, go to SCROLL with index 0, latch speed_in into speed_r and clear pending.
- Spawn handshake: accept when spawn_valid_in && spawn_ready_out. The lowest-index inactive slot is written at the same clock edge: {type, SPAWN_POS, lane, 1}. Lane 3 is consumed (handshake completes) but no slot is written. A tick arriving in the accepting cycle is only pended; the spawn still completes.
- FSM SCROLL: one slot per cycle, index 0..NUM_SLOTS-1, busy_out = 1, spawn_ready_out = 0.
  - Active slot with pos < speed_r: active bit cleared (other fields kept) and passed_out pulsed that cycle.
  - Active slot with pos >= speed_r: pos = pos - speed_r (10-bit, no wrap).
  - Inactive slots are untouched.
  - After index NUM_SLOTS-1, return to IDLE. A pass takes exactly NUM_SLOTS cycles.
  - speed_r = 0: pass runs, positions are unchanged, nothing retires.
- active_count_out: registered popcount of the active bits, updated the cycle after any table change.
- clear_in: the same edge zeroes all slots, aborts SCROLL to IDLE, clears pending and refuses spawns that cycle. It has priority over spawn and scroll.
- Reset asserted mid-scroll: immediate return to the reset state; no partial outputs persist.
- Table full (10 active): spawn_ready_out = 0; the requester holds valid until a slot frees.

Test Plan:
- Reset, then spawn type 1, lane 2 -> slot 0 = {2'd1, 10'd1023, 2'd2, 1}; active_count_out = 1 one cycle later; spawn_ready_out stays 1.
- One obstacle at pos 1023, speed 5, one vsync fall -> busy_out high for 10 cycles; pos = 1018; no passed_out.
- Obstacle at pos 3, speed 4, tick -> active bit cleared, exactly one passed_out pulse, active_count_out returns to 0.
- Spawn 10 obstacles -> spawn_ready_out = 0 with valid held. One retires on a tick -> ready rises in IDLE; the 11th spawn lands in the freed slot index.
- Spawn with lane 3 -> handshake completes; table and active_count_out unchanged. A tick in the same cycle as a valid spawn -> spawn written first, scroll starts on the next cycle and scrolls the new slot.
- Checks during a scroll pass:
  - pause_in high during vsync fall -> no scroll.
  - clear_in during SCROLL at index 4 -> all slots 0, FSM IDLE.
  - reset_n_in low at index 6 -> all outputs 0 immediately.

Source files
------------

// File: rtl/obstacle_manager.sv
// obstacle_manager: 10-slot obstacle table with spawn handshake, per-frame scroll pass and retirement.
module obstacle_manager #(
  parameter int          NUM_SLOTS = 10,
  parameter logic [9:0]  SPAWN_POS = 10'd1023,
  parameter int          SPEED_W   = 4
) (
  input  logic                           system_clock_in,
  input  logic                           reset_n_in,
  input  logic                           vsync_in,
  input  logic                           pause_in,
  input  logic                           clear_in,
  input  logic [SPEED_W-1:0]             speed_in,
  input  logic                           spawn_valid_in,
  output logic                           spawn_ready_out,
  input  logic [1:0]                     spawn_type_in,
  input  logic [1:0]                     spawn_lane_in,
  output logic [NUM_SLOTS-1:0][14:0]     obstacles_out,
  output logic [3:0]                     active_count_out,
  output logic                           passed_out,
  output logic                           busy_out
);
  typedef enum logic {IDLE, SCROLL} state_t;
  localparam logic [3:0] LAST = 4'(NUM_SLOTS - 1);
  state_t state, state_n;
  logic [3:0] idx, idx_n, free_idx, cnt;
  logic [SPEED_W-1:0] speed_r, speed_n;
  logic pending, pending_n, vsync_r, tick, accept, passed_n, has_free, free_n, ready_n;
  logic [NUM_SLOTS-1:0][14:0] tbl_n;
  logic [14:0] cur;
  logic [9:0] spd10;
  assign tick     = vsync_r & ~vsync_in;
  assign accept   = spawn_valid_in & spawn_ready_out & ~clear_in;
  assign busy_out = state == SCROLL;
  assign spd10    = 10'(speed_r);
  assign cur      = obstacles_out[idx];
  always_comb begin
    has_free = 1'b0;
    free_idx = '0;
    cnt      = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      cnt = cnt + 4'(obstacles_out[i][0]);
      if (!obstacles_out[i][0]) begin
        has_free = 1'b1;
        free_idx = 4'(i);
      end
    end
  end
  always_comb begin
    tbl_n     = obstacles_out;
    state_n   = state;
    idx_n     = idx;
    speed_n   = speed_r;
    pending_n = pending;
    passed_n  = 1'b0;
    if (clear_in) begin
      tbl_n     = '0;
      state_n   = IDLE;
      idx_n     = '0;
      pending_n = 1'b0;
    end else begin
      if (state == IDLE && pending) begin
        state_n   = SCROLL;
        idx_n     = '0;
        speed_n   = speed_in;
        pending_n = 1'b0;
      end else if (tick && !pause_in) pending_n = 1'b1;
      // lane 3 completes the handshake but never occupies a slot
      if (accept && has_free && spawn_lane_in != 2'd3)
        tbl_n[free_idx] = {spawn_type_in, SPAWN_POS, spawn_lane_in, 1'b1};
      if (state == SCROLL) begin
        if (cur[0]) begin
          if (cur[12:3] < spd10) begin
            tbl_n[idx][0] = 1'b0;
            passed_n      = 1'b1;
          end else tbl_n[idx][12:3] = cur[12:3] - spd10;
        end
        idx_n   = idx == LAST ? 4'd0 : idx + 4'd1;
        state_n = idx == LAST ? IDLE : SCROLL;
      end
    end
    free_n = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) free_n = free_n | ~tbl_n[i][0];
    ready_n = state_n == IDLE && !pending_n && free_n;
  end
  always_ff @(posedge system_clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      obstacles_out    <= '0;
      active_count_out <= '0;
      passed_out       <= 1'b0;
      spawn_ready_out  <= 1'b0;
      state            <= IDLE;
      idx              <= '0;
      speed_r          <= '0;
      pending          <= 1'b0;
      vsync_r          <= 1'b1;
    end else begin
      obstacles_out    <= tbl_n;
      active_count_out <= cnt;
      passed_out       <= passed_n;
      spawn_ready_out  <= ready_n;
      state            <= state_n;
      idx              <= idx_n;
      speed_r          <= speed_n;
      pending          <= pending_n;
      vsync_r          <= vsync_in;
    end
  end
endmodule

// File: tb/tb_obstacle_manager.sv
// tb_obstacle_manager: table-driven scroll vectors with a scoreboard queue plus hand-written corner sequences.
module tb_obstacle_manager;
  logic clk = 1'b0, rst_n = 1'b0, vsync = 1'b1, pause = 1'b0, clear = 1'b0;
  logic [3:0] speed = '0;
  logic valid = 1'b0, ready, passed, busy;
  logic [1:0] typ = '0, lane = '0;
  logic [9:0][14:0] obs;
  logic [3:0] count;
  int n_tests = 0, n_fail = 0, pcount = 0, bcount = 0;

  obstacle_manager dut (
    .system_clock_in(clk), .reset_n_in(rst_n), .vsync_in(vsync), .pause_in(pause),
    .clear_in(clear), .speed_in(speed), .spawn_valid_in(valid), .spawn_ready_out(ready),
    .spawn_type_in(typ), .spawn_lane_in(lane), .obstacles_out(obs),
    .active_count_out(count), .passed_out(passed), .busy_out(busy)
  );

  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (passed) pcount++;
    if (busy) bcount++;
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 5ms");
    $fatal(1);
  end

  typedef struct {
    logic [1:0] typ;
    logic [1:0] lane;
    logic [3:0] spd;
    int         nt;
    logic [9:0] pos;
    logic       act;
    int         passed;
  } vec_t;
  typedef struct {
    logic [14:0] slot;
    logic [3:0]  cnt;
    int          passed;
    int          busy;
  } exp_t;
  vec_t vecs[8];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0; valid = 1'b0; clear = 1'b0; pause = 1'b0; vsync = 1'b1; speed = '0;
    step(2);
    rst_n = 1'b1;
    step(2);
  endtask
  task automatic wait_ready(input string name);
    int n = 0;
    while (!ready && n < 100) begin
      step(1);
      n++;
    end
    if (!ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: spawn_ready_out stayed 0 for 100 cycles, required 1", name);
    end
  endtask
  task automatic spawn(input logic [1:0] t, input logic [1:0] l);
    wait_ready("spawn_wait");
    valid = 1'b1; typ = t; lane = l;
    step(1);
    valid = 1'b0;
  endtask
  task automatic tick_pass(input logic [3:0] s);
    speed = s; vsync = 1'b0;
    step(1);
    vsync = 1'b1;
    step(12);
  endtask

  initial begin
    int p0, b0;
    exp_t e;
    vecs[0] = '{2'd1, 2'd2, 4'd5,   1, 10'd1018, 1'b1, 0};
    vecs[1] = '{2'd0, 2'd0, 4'd0,   3, 10'd1023, 1'b1, 0};
    vecs[2] = '{2'd3, 2'd1, 4'd15, 68, 10'd3,    1'b1, 0};
    vecs[3] = '{2'd3, 2'd1, 4'd15, 69, 10'd3,    1'b0, 1};
    vecs[4] = '{2'd2, 2'd2, 4'd11, 93, 10'd0,    1'b1, 0};
    vecs[5] = '{2'd2, 2'd0, 4'd11, 94, 10'd0,    1'b0, 1};
    vecs[6] = '{2'd1, 2'd1, 4'd4, 256, 10'd3,    1'b0, 1};
    vecs[7] = '{2'd1, 2'd3, 4'd5,   1, 10'd0,    1'b0, 0};

    step(2);
    check("rst_table", 32'(obs == '0), 1);
    check("rst_count", 32'(count), 0);
    check("rst_ready", 32'(ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_passed", 32'(passed), 0);
    rst_n = 1'b1;
    step(2);
    check("ready_after_rst", 32'(ready), 1);

    spawn(2'd1, 2'd2);
    check("spawn_slot0", 32'(obs[0]), 32'({2'd1, 10'd1023, 2'd2, 1'b1}));
    step(1);
    check("spawn_count", 32'(count), 1);
    check("spawn_ready", 32'(ready), 1);

    foreach (vecs[i]) begin
      do_reset();
      spawn(vecs[i].typ, vecs[i].lane);
      p0 = pcount;
      b0 = bcount;
      sb.push_back('{vecs[i].lane == 2'd3 ? 15'd0 : {vecs[i].typ, vecs[i].pos, vecs[i].lane, vecs[i].act},
                     4'(vecs[i].act), vecs[i].passed, 10 * vecs[i].nt});
      repeat (vecs[i].nt) tick_pass(vecs[i].spd);
      step(1);
      e = sb.pop_front();
      check($sformatf("vec%0d_slot0", i), 32'(obs[0]), 32'(e.slot));
      check($sformatf("vec%0d_slot1", i), 32'(obs[1]), 0);
      check($sformatf("vec%0d_count", i), 32'(count), 32'(e.cnt));
      check($sformatf("vec%0d_passed", i), 32'(pcount - p0), 32'(e.passed));
      check($sformatf("vec%0d_busy", i), 32'(bcount - b0), 32'(e.busy));
    end

    do_reset();
    spawn(2'd0, 2'd0);
    repeat (68) tick_pass(4'd15);
    for (int i = 1; i < 10; i++) spawn(2'(i % 4), 2'(i % 3));
    check("full_ready", 32'(ready), 0);
    step(1);
    check("full_count", 32'(count), 10);
    valid = 1'b1; typ = 2'd3; lane = 2'd1;
    step(3);
    check("full_held_ready", 32'(ready), 0);
    check("full_held_slot0", 32'(obs[0]), 32'({2'd0, 10'd3, 2'd0, 1'b1}));
    p0 = pcount;
    tick_pass(4'd4);
    valid = 1'b0;
    check("full_refill_slot0", 32'(obs[0]), 32'({2'd3, 10'd1023, 2'd1, 1'b1}));
    check("full_slot1", 32'(obs[1]), 32'({2'd1, 10'd1019, 2'd1, 1'b1}));
    check("full_retired", 32'(pcount - p0), 1);
    step(2);
    check("full_count2", 32'(count), 10);
    check("full_ready2", 32'(ready), 0);

    do_reset();
    spawn(2'd1, 2'd3);
    step(2);
    check("lane3_slot0", 32'(obs[0]), 0);
    check("lane3_count", 32'(count), 0);
    check("lane3_ready", 32'(ready), 1);

    do_reset();
    wait_ready("same_cycle_wait");
    valid = 1'b1; typ = 2'd2; lane = 2'd0; speed = 4'd7; vsync = 1'b0;
    step(1);
    valid = 1'b0; vsync = 1'b1;
    check("same_cycle_slot0", 32'(obs[0]), 32'({2'd2, 10'd1023, 2'd0, 1'b1}));
    check("same_cycle_busy0", 32'(busy), 0);
    step(1);
    check("same_cycle_busy1", 32'(busy), 1);
    step(12);
    check("same_cycle_scrolled", 32'(obs[0]), 32'({2'd2, 10'd1016, 2'd0, 1'b1}));

    do_reset();
    spawn(2'd1, 2'd1);
    b0 = bcount;
    pause = 1'b1;
    tick_pass(4'd5);
    pause = 1'b0;
    step(5);
    check("pause_busy", 32'(bcount - b0), 0);
    check("pause_slot0", 32'(obs[0]), 32'({2'd1, 10'd1023, 2'd1, 1'b1}));

    do_reset();
    spawn(2'd1, 2'd0);
    spawn(2'd2, 2'd1);
    speed = 4'd1; vsync = 1'b0;
    step(1);
    vsync = 1'b1;
    step(5);
    check("clear_busy_before", 32'(busy), 1);
    check("clear_slot0_before", 32'(obs[0]), 32'({2'd1, 10'd1022, 2'd0, 1'b1}));
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("clear_table", 32'(obs == '0), 1);
    check("clear_busy", 32'(busy), 0);
    step(1);
    check("clear_count", 32'(count), 0);
    check("clear_ready", 32'(ready), 1);

    do_reset();
    spawn(2'd3, 2'd2);
    speed = 4'd2; vsync = 1'b0;
    step(1);
    vsync = 1'b1;
    step(7);
    check("rstmid_busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("rstmid_table", 32'(obs == '0), 1);
    check("rstmid_count", 32'(count), 0);
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_ready", 32'(ready), 0);
    step(2);
    rst_n = 1'b1;
    step(2);
    check("rstmid_ready_after", 32'(ready), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
